// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared types and constants for the two-master pmem arbiter.
package pmem_arb_pkg;
  localparam int ID_W = 1;
  localparam int LEN_W = 8;
  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;
endpackage

// File: rtl/pmem_arb2_tag_fifo.sv
// pmem_arb2_tag_fifo: small FIFO of master ids recording the order of accepted beats.
module pmem_arb2_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(do_push);
      rptr_q <= rptr_q + AW'(do_pop);
      cnt_q  <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/pmem_arb2.sv
// pmem_arb2: two-master burst arbiter onto one pipelined RAM port, with
// in-order response routing through a tag FIFO of accepted beats.
module pmem_arb2
  import pmem_arb_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        m0_wr_i,
  input  logic              m0_rd_i,
  input  logic [LEN_W-1:0]  m0_len_i,
  input  logic [31:0]       m0_addr_i,
  input  logic [31:0]       m0_write_data_i,
  output logic              m0_accept_o,
  output logic              m0_ack_o,
  output logic              m0_error_o,
  output logic [31:0]       m0_read_data_o,
  input  logic [3:0]        m1_wr_i,
  input  logic              m1_rd_i,
  input  logic [LEN_W-1:0]  m1_len_i,
  input  logic [31:0]       m1_addr_i,
  input  logic [31:0]       m1_write_data_i,
  output logic              m1_accept_o,
  output logic              m1_ack_o,
  output logic              m1_error_o,
  output logic [31:0]       m1_read_data_o,
  output logic [3:0]        ram_wr_o,
  output logic              ram_rd_o,
  output logic [LEN_W-1:0]  ram_len_o,
  output logic [31:0]       ram_addr_o,
  output logic [31:0]       ram_write_data_o,
  input  logic              ram_accept_i,
  input  logic              ram_ack_i,
  input  logic              ram_error_i,
  input  logic [31:0]       ram_read_data_i,
  output logic              unexp_ack_o
);
  state_e state_q, state_d;
  logic owner_q, owner_d, prio_q, prio_d, unexp_q, unexp_d;
  logic [LEN_W-1:0] beats_q, beats_d, sel_len;
  logic req0, req1, gnt_id, gnt_vld, fwd, accept, pop, full, empty;
  logic [ID_W-1:0] head_id;
  logic [$clog2(OUTSTANDING):0] cnt;
  assign req0 = m0_rd_i | (|m0_wr_i);
  assign req1 = m1_rd_i | (|m1_wr_i);
  // In BURST only the owner is forwarded; in IDLE prio breaks ties.
  assign gnt_id  = state_q == S_BURST ? owner_q : (req0 & req1) ? prio_q : req1;
  assign gnt_vld = rst_ni & (gnt_id ? req1 : req0);
  assign fwd     = gnt_vld & ~full;
  assign accept  = fwd & ram_accept_i;
  assign pop     = rst_ni & ram_ack_i & ~empty;
  assign sel_len = gnt_id ? m1_len_i : m0_len_i;
  pmem_arb2_tag_fifo #(.WIDTH(ID_W), .DEPTH(OUTSTANDING)) u_tags (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  (gnt_id),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      beats_q <= '0;
      unexp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      beats_q <= beats_d;
      unexp_q <= unexp_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    beats_d = beats_q;
    unexp_d = unexp_q | (ram_ack_i & (cnt == '0));
    if (accept) begin
      if (state_q == S_IDLE) begin
        if (sel_len == '0) begin
          prio_d = ~gnt_id;
        end else begin
          state_d = S_BURST;
          owner_d = gnt_id;
          beats_d = sel_len;
        end
      end else begin
        beats_d = beats_q - LEN_W'(1);
        if (beats_q == LEN_W'(1)) begin
          state_d = S_IDLE;
          prio_d  = ~owner_q;
        end
      end
    end
  end
  always_comb begin
    ram_wr_o         = fwd ? (gnt_id ? m1_wr_i : m0_wr_i) : 4'h0;
    ram_rd_o         = fwd & (gnt_id ? m1_rd_i : m0_rd_i);
    ram_len_o        = state_q == S_IDLE ? sel_len : '0;
    ram_addr_o       = gnt_id ? m1_addr_i : m0_addr_i;
    ram_write_data_o = gnt_id ? m1_write_data_i : m0_write_data_i;
    m0_accept_o      = accept & ~gnt_id;
    m1_accept_o      = accept & gnt_id;
    m0_ack_o         = pop & ~head_id[0];
    m1_ack_o         = pop & head_id[0];
    m0_error_o       = m0_ack_o & ram_error_i;
    m1_error_o       = m1_ack_o & ram_error_i;
    m0_read_data_o   = ram_read_data_i;
    m1_read_data_o   = ram_read_data_i;
    unexp_ack_o      = unexp_q;
  end
endmodule

// File: tb/tb_pmem_arb2.sv
// tb_pmem_arb2: directed vector table plus hand sequences for bursts, back-pressure and reset.
module tb_pmem_arb2;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic [3:0] m0_wr_i, m1_wr_i, ram_wr_o;
  logic m0_rd_i, m1_rd_i, ram_rd_o;
  logic [7:0] m0_len_i, m1_len_i, ram_len_o;
  logic [31:0] m0_addr_i, m1_addr_i, m0_write_data_i, m1_write_data_i;
  logic [31:0] m0_read_data_o, m1_read_data_o, ram_addr_o, ram_write_data_o, ram_read_data_i;
  logic m0_accept_o, m1_accept_o, m0_ack_o, m1_ack_o, m0_error_o, m1_error_o;
  logic ram_accept_i, ram_ack_i, ram_error_i, unexp_ack_o;
  int total = 0;
  int bad = 0;
  int n;
  always #5 clk_i = ~clk_i;
  pmem_arb2 #(.OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_wr_i(m0_wr_i), .m0_rd_i(m0_rd_i), .m0_len_i(m0_len_i), .m0_addr_i(m0_addr_i),
    .m0_write_data_i(m0_write_data_i), .m0_accept_o(m0_accept_o), .m0_ack_o(m0_ack_o),
    .m0_error_o(m0_error_o), .m0_read_data_o(m0_read_data_o),
    .m1_wr_i(m1_wr_i), .m1_rd_i(m1_rd_i), .m1_len_i(m1_len_i), .m1_addr_i(m1_addr_i),
    .m1_write_data_i(m1_write_data_i), .m1_accept_o(m1_accept_o), .m1_ack_o(m1_ack_o),
    .m1_error_o(m1_error_o), .m1_read_data_o(m1_read_data_o),
    .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_len_o(ram_len_o), .ram_addr_o(ram_addr_o),
    .ram_write_data_o(ram_write_data_o), .ram_accept_i(ram_accept_i), .ram_ack_i(ram_ack_i),
    .ram_error_i(ram_error_i), .ram_read_data_i(ram_read_data_i), .unexp_ack_o(unexp_ack_o)
  );
  typedef struct {
    logic m0_rd; logic [3:0] m0_wr; logic m1_rd; logic [3:0] m1_wr; logic acc; logic ack;
    logic e_a0; logic e_a1; logic e_k0; logic e_k1; logic e_rd; logic [3:0] e_wr; logic [31:0] e_addr;
  } vec_t;
  vec_t vt[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic clear_in();
    m0_wr_i = 4'h0; m1_wr_i = 4'h0; m0_rd_i = 1'b0; m1_rd_i = 1'b0;
    m0_len_i = 8'h0; m1_len_i = 8'h0; ram_accept_i = 1'b0; ram_ack_i = 1'b0;
  endtask
  task automatic do_reset();
    clear_in();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    m0_addr_i = A0; m1_addr_i = A1;
    m0_write_data_i = 32'hD0; m1_write_data_i = 32'hD1;
    ram_error_i = 1'b0; ram_read_data_i = 32'h0;
    clear_in();
    rst_ni = 1'b0;
    vt[0] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, A0};
    vt[1] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, A1};
    vt[2] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0};
    vt[3] = '{1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, A1};
    vt[4] = '{1'b0, 4'h3, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, A0};
    vt[5] = '{1'b0, 4'h3, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, A0};
    vt[6] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, A1};
    vt[7] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, A0};
    vt[8] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
    // Outputs stay quiet under reset even with requests and an ack present.
    m0_rd_i = 1'b1; m1_rd_i = 1'b1; ram_accept_i = 1'b1; ram_ack_i = 1'b1;
    #3;
    chk("rst_acc0", m0_accept_o, 0);
    chk("rst_acc1", m1_accept_o, 0);
    chk("rst_rd", ram_rd_o, 0);
    chk("rst_ack0", m0_ack_o, 0);
    chk("rst_unexp", unexp_ack_o, 0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      m0_rd_i = vt[i].m0_rd; m0_wr_i = vt[i].m0_wr; m1_rd_i = vt[i].m1_rd; m1_wr_i = vt[i].m1_wr;
      ram_accept_i = vt[i].acc; ram_ack_i = vt[i].ack; ram_read_data_i = 32'hA500 + i;
      #1;
      chk($sformatf("v%0d_acc0", i), m0_accept_o, vt[i].e_a0);
      chk($sformatf("v%0d_acc1", i), m1_accept_o, vt[i].e_a1);
      chk($sformatf("v%0d_ack0", i), m0_ack_o, vt[i].e_k0);
      chk($sformatf("v%0d_ack1", i), m1_ack_o, vt[i].e_k1);
      chk($sformatf("v%0d_rd", i), ram_rd_o, vt[i].e_rd);
      chk($sformatf("v%0d_wr", i), ram_wr_o, vt[i].e_wr);
      if (vt[i].e_rd || vt[i].e_wr != 4'h0) chk($sformatf("v%0d_addr", i), ram_addr_o, vt[i].e_addr);
      if (vt[i].e_k0) chk($sformatf("v%0d_rdata0", i), m0_read_data_o, 32'hA500 + i);
      if (vt[i].e_k1) chk($sformatf("v%0d_rdata1", i), m1_read_data_o, 32'hA500 + i);
      tick();
    end
    chk("vec_unexp", unexp_ack_o, 0);
    // m0 write burst len=3 against a waiting m1 reader.
    do_reset();
    m0_wr_i = 4'hF; m0_len_i = 8'd3; m1_rd_i = 1'b1; ram_accept_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ram_ack_i = c > 0;
      #1;
      chk($sformatf("b%0d_acc0", c), m0_accept_o, 1);
      chk($sformatf("b%0d_acc1", c), m1_accept_o, 0);
      chk($sformatf("b%0d_len", c), ram_len_o, c == 0 ? 3 : 0);
      chk($sformatf("b%0d_ack0", c), m0_ack_o, c > 0);
      if (c == 0) chk("b0_wdata", ram_write_data_o, 32'hD0);
      tick();
    end
    #1;
    chk("b4_acc1", m1_accept_o, 1);
    chk("b4_acc0", m0_accept_o, 0);
    chk("b4_ack0", m0_ack_o, 1);
    tick();
    clear_in();
    ram_ack_i = 1'b1;
    #1;
    chk("b5_ack1", m1_ack_o, 1);
    chk("b5_ack0", m0_ack_o, 0);
    tick();
    // Back-pressure from a full tag FIFO, including ack and full in the same cycle.
    do_reset();
    m0_rd_i = 1'b1; ram_accept_i = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n += int'(m0_accept_o);
      if (c >= 4) chk($sformatf("f%0d_rd", c), ram_rd_o, 0);
      tick();
    end
    chk("fill_count", n, 4);
    ram_ack_i = 1'b1;
    #1;
    chk("full_pop_acc", m0_accept_o, 0);
    chk("full_pop_ack", m0_ack_o, 1);
    tick();
    ram_ack_i = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n += int'(m0_accept_o);
      tick();
    end
    chk("refill_count", n, 1);
    // Stall in the middle of a len=2 burst.
    do_reset();
    m0_rd_i = 1'b1; m0_len_i = 8'd2; m1_rd_i = 1'b1; ram_accept_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      ram_accept_i = !(c >= 2 && c <= 4);
      #1;
      chk($sformatf("s%0d_acc0", c), m0_accept_o, c < 2 || c == 5);
      chk($sformatf("s%0d_acc1", c), m1_accept_o, c == 6);
      if (c >= 1 && c <= 5) begin
        chk($sformatf("s%0d_addr", c), ram_addr_o, A0);
        chk($sformatf("s%0d_len", c), ram_len_o, 0);
      end
      tick();
    end
    // Ack with nothing outstanding.
    do_reset();
    ram_ack_i = 1'b1;
    #1;
    chk("ux_ack0", m0_ack_o, 0);
    chk("ux_ack1", m1_ack_o, 0);
    tick();
    ram_ack_i = 1'b0;
    tick();
    tick();
    chk("ux_sticky", unexp_ack_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("ux_cleared", unexp_ack_o, 0);
    // Reset in the middle of a burst with two beats outstanding.
    do_reset();
    m0_rd_i = 1'b1; m0_len_i = 8'd3; ram_accept_i = 1'b1;
    tick();
    tick();
    rst_ni = 1'b0; ram_ack_i = 1'b1;
    #1;
    chk("rb_acc0", m0_accept_o, 0);
    chk("rb_rd", ram_rd_o, 0);
    chk("rb_ack0", m0_ack_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    clear_in();
    m1_rd_i = 1'b1; m1_len_i = 8'd7;
    #1;
    chk("rb_idle_len", ram_len_o, 7);
    chk("rb_idle_addr", ram_addr_o, A1);
    chk("rb_idle_rd", ram_rd_o, 1);
    tick();
    clear_in();
    ram_ack_i = 1'b1;
    #1;
    chk("rb_ack0_none", m0_ack_o, 0);
    chk("rb_ack1_none", m1_ack_o, 0);
    tick();
    ram_ack_i = 1'b0;
    #1;
    chk("rb_unexp", unexp_ack_o, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
